// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer.
// Digit-pair validity is checked here so loads and counters agree on the limits.
package bcd_timer_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;
  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic logic pair_valid(input bcd_t tens, input bcd_t unit, input bcd_t tens_max);
    return (tens <= tens_max) && (unit <= DIGIT_MAX);
  endfunction
endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD modulo counter (units 0..9, tens 0..TENS_MAX), up or down.
// borrow/carry flag that the next step in the current direction wraps the pair.
module bcd_pair_cnt
  import bcd_timer_pkg::*;
#(
  parameter int TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_unit,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] tens,
  output logic [3:0] unit,
  output logic       borrow,
  output logic       carry
);
  localparam bcd_t TMAX = bcd_t'(TENS_MAX);

  logic [3:0] r_tens, r_unit;

  assign tens   = r_tens;
  assign unit   = r_unit;
  assign borrow = (r_tens == 4'd0) && (r_unit == 4'd0);
  assign carry  = (r_tens == TMAX) && (r_unit == DIGIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens <= 4'd0;
      r_unit <= 4'd0;
    end else if (load) begin
      r_tens <= ld_tens;
      r_unit <= ld_unit;
    end else if (step) begin
      if (dir) begin
        if (r_unit == DIGIT_MAX) begin
          r_unit <= 4'd0;
          r_tens <= (r_tens == TMAX) ? 4'd0 : r_tens + 4'd1;
        end else begin
          r_unit <= r_unit + 4'd1;
        end
      end else begin
        if (r_unit == 4'd0) begin
          r_unit <= DIGIT_MAX;
          r_tens <= (r_tens == 4'd0) ? TMAX : r_tens - 4'd1;
        end else begin
          r_unit <= r_unit - 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/bcd_timer_gen2.sv
// mm:ss BCD up/down timer with pause, validated loads and sticky DONE.
// Define BCD_TIMER_AUTO_RELOAD_EN for periodic countdowns reloaded from the last valid load.
module bcd_timer_gen2
  import bcd_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRE_W         = 26,
  parameter int MIN_TENS_MAX  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_sec,
  input  logic       set_min,
  input  logic [3:0] unit_in,
  input  logic [3:0] tens_in,
  input  logic       up_mode,
  input  logic       start,
  input  logic       pause,
  input  logic       ack,
  output logic [3:0] unit_sec,
  output logic [3:0] tens_sec,
  output logic [3:0] unit_min,
  output logic [3:0] tens_min,
  output logic       timesup,
  output logic       running,
  output logic       sec_tick,
  output logic       load_err
);
  localparam bcd_t             MIN_TMAX = bcd_t'(MIN_TENS_MAX);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  state_t           r_state;
  logic             r_up;
  logic [PRE_W-1:0] r_pre;
  logic             r_timesup, r_running, r_sec_tick, r_load_err;

  logic [3:0] w_sec_t, w_sec_u, w_min_t, w_min_u;
  logic [3:0] w_sec_ld_t, w_sec_ld_u, w_min_ld_t, w_min_ld_u;
  logic       w_sec_bor, w_sec_car, w_min_bor, w_min_car;
  logic       w_loadable, w_ld_sec, w_ld_min, w_sec_ok, w_min_ok;
  logic       w_ld_sec_ok, w_ld_min_ok, w_ld_bad;
  logic       w_tick, w_zero, w_max, w_last_dn, w_last_up, w_last, w_reload;

  assign w_loadable  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_ld_sec    = w_loadable && set_sec;
  assign w_ld_min    = w_loadable && set_min && !set_sec;
  assign w_sec_ok    = pair_valid(tens_in, unit_in, SEC_TENS_MAX);
  assign w_min_ok    = pair_valid(tens_in, unit_in, MIN_TMAX);
  assign w_ld_sec_ok = w_ld_sec && w_sec_ok;
  assign w_ld_min_ok = w_ld_min && w_min_ok;
  assign w_ld_bad    = (w_ld_sec && !w_sec_ok) || (w_ld_min && !w_min_ok);

  assign w_tick    = (r_state == ST_RUN) && !pause && (r_pre == PRE_LAST);
  assign w_zero    = w_sec_bor && w_min_bor;
  assign w_max     = w_sec_car && w_min_car;
  // "Last" means the step about to be applied lands on the terminal value.
  assign w_last_dn = w_min_bor && (w_sec_t == 4'd0) && (w_sec_u == 4'd1);
  assign w_last_up = w_min_car && (w_sec_t == SEC_TENS_MAX) && (w_sec_u == 4'd8);
  assign w_last    = r_up ? w_last_up : w_last_dn;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [3:0] r_rel_st, r_rel_su, r_rel_mt, r_rel_mu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rel_st <= 4'd0;
      r_rel_su <= 4'd0;
      r_rel_mt <= 4'd0;
      r_rel_mu <= 4'd0;
    end else if (w_ld_sec_ok) begin
      r_rel_st <= tens_in;
      r_rel_su <= unit_in;
    end else if (w_ld_min_ok) begin
      r_rel_mt <= tens_in;
      r_rel_mu <= unit_in;
    end
  end

  assign w_reload   = w_tick && !r_up && w_last_dn &&
                      ({r_rel_mt, r_rel_mu, r_rel_st, r_rel_su} != 16'd0);
  assign w_sec_ld_t = w_reload ? r_rel_st : tens_in;
  assign w_sec_ld_u = w_reload ? r_rel_su : unit_in;
  assign w_min_ld_t = w_reload ? r_rel_mt : tens_in;
  assign w_min_ld_u = w_reload ? r_rel_mu : unit_in;
`else
  assign w_reload   = 1'b0;
  assign w_sec_ld_t = tens_in;
  assign w_sec_ld_u = unit_in;
  assign w_min_ld_t = tens_in;
  assign w_min_ld_u = unit_in;
`endif

  bcd_pair_cnt #(.TENS_MAX(5)) u_sec (
    .clk     (clk),
    .rst     (reset),
    .load    (w_ld_sec_ok || w_reload),
    .ld_tens (w_sec_ld_t),
    .ld_unit (w_sec_ld_u),
    .step    (w_tick && !w_reload),
    .dir     (r_up),
    .tens    (w_sec_t),
    .unit    (w_sec_u),
    .borrow  (w_sec_bor),
    .carry   (w_sec_car)
  );

  bcd_pair_cnt #(.TENS_MAX(MIN_TENS_MAX)) u_min (
    .clk     (clk),
    .rst     (reset),
    .load    (w_ld_min_ok || w_reload),
    .ld_tens (w_min_ld_t),
    .ld_unit (w_min_ld_u),
    .step    (w_tick && !w_reload && (r_up ? w_sec_car : w_sec_bor)),
    .dir     (r_up),
    .tens    (w_min_t),
    .unit    (w_min_u),
    .borrow  (w_min_bor),
    .carry   (w_min_car)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_up       <= 1'b0;
      r_pre      <= '0;
      r_timesup  <= 1'b0;
      r_running  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      r_load_err <= w_ld_bad;
      case (r_state)
        ST_IDLE: if (start) begin
          r_up  <= up_mode;
          r_pre <= '0;
          if (up_mode ? w_max : w_zero) begin
            r_state   <= ST_DONE;
            r_timesup <= 1'b1;
          end else begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          r_timesup <= 1'b0;
          if (pause) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end else if (r_pre == PRE_LAST) begin
            r_pre      <= '0;
            r_sec_tick <= 1'b1;
            if (w_reload) begin
              r_timesup <= 1'b1;
            end else if (w_last) begin
              r_state   <= ST_DONE;
              r_timesup <= 1'b1;
              r_running <= 1'b0;
            end
          end else begin
            r_pre <= r_pre + PRE_W'(1);
          end
        end
        ST_PAUSE: if (start) begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        ST_DONE: if (ack || w_ld_sec_ok || w_ld_min_ok) begin
          r_state   <= ST_IDLE;
          r_timesup <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign unit_sec = w_sec_u;
  assign tens_sec = w_sec_t;
  assign unit_min = w_min_u;
  assign tens_min = w_min_t;
  assign timesup  = r_timesup;
  assign running  = r_running;
  assign sec_tick = r_sec_tick;
  assign load_err = r_load_err;
endmodule

// File: tb/tb_bcd_timer_gen2.sv
// Bench for bcd_timer_gen2: time-in-seconds reference model compared every cycle,
// plus hand-computed literal checks along a directed scenario.
module tb_bcd_timer_gen2;
  localparam int T    = 4;
  localparam int MTM  = 9;
  localparam int MAXS = (MTM * 10 + 9) * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk = 1'b0, reset = 1'b1;
  logic set_sec = 0, set_min = 0, up_mode = 0, start = 0, pause = 0, ack = 0;
  logic [3:0] unit_in = 0, tens_in = 0;
  logic [3:0] unit_sec, tens_sec, unit_min, tens_min;
  logic timesup, running, sec_tick, load_err;

  int n_tests = 0, n_fail = 0;

  bcd_timer_gen2 #(.TICKS_PER_SEC(T), .PRE_W(3), .MIN_TENS_MAX(MTM)) dut (
    .clk(clk), .reset(reset), .set_sec(set_sec), .set_min(set_min),
    .unit_in(unit_in), .tens_in(tens_in), .up_mode(up_mode), .start(start),
    .pause(pause), .ack(ack), .unit_sec(unit_sec), .tens_sec(tens_sec),
    .unit_min(unit_min), .tens_min(tens_min), .timesup(timesup),
    .running(running), .sec_tick(sec_tick), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as a plain number of seconds.
  int m_st, m_t, m_pre, m_rel;
  bit m_up, m_tick, m_err, m_tsup;

  always @(posedge clk or posedge reset) begin
    int st0, t0, nt, v;
    bit lv;
    if (reset) begin
      m_st = S_IDLE; m_t = 0; m_pre = 0; m_rel = 0;
      m_up = 0; m_tick = 0; m_err = 0; m_tsup = 0;
    end else begin
      st0 = m_st; t0 = m_t; m_tick = 0; m_err = 0; lv = 0;
      v = int'(tens_in) * 10 + int'(unit_in);
      case (st0)
        S_IDLE: if (start) begin
          m_up = up_mode; m_pre = 0;
          if (up_mode ? (t0 == MAXS) : (t0 == 0)) begin m_st = S_DONE; m_tsup = 1; end
          else m_st = S_RUN;
        end
        S_RUN: begin
          m_tsup = 0;
          if (pause) m_st = S_PAUSE;
          else if (m_pre == T - 1) begin
            m_pre = 0; m_tick = 1;
            nt = m_up ? t0 + 1 : t0 - 1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (!m_up && nt == 0 && m_rel != 0) begin m_t = m_rel; m_tsup = 1; end
            else
`endif
            begin
              m_t = nt;
              if (m_up ? (nt == MAXS) : (nt == 0)) begin m_st = S_DONE; m_tsup = 1; end
            end
          end else m_pre = m_pre + 1;
        end
        S_PAUSE: if (start) m_st = S_RUN;
        default: if (ack) begin m_st = S_IDLE; m_tsup = 0; end
      endcase
      if (st0 == S_IDLE || st0 == S_DONE) begin
        if (set_sec) begin
          if (tens_in <= 5 && unit_in <= 9) begin
            m_t = (m_t / 60) * 60 + v; m_rel = (m_rel / 60) * 60 + v; lv = 1;
          end else m_err = 1;
        end else if (set_min) begin
          if (tens_in <= MTM && unit_in <= 9) begin
            m_t = m_t % 60 + v * 60; m_rel = m_rel % 60 + v * 60; lv = 1;
          end else m_err = 1;
        end
        if (lv && st0 == S_DONE) begin m_st = S_IDLE; m_tsup = 0; end
      end
    end
  end

  function automatic logic [19:0] model_out();
    return {4'(m_t / 600), 4'((m_t / 60) % 10), 4'((m_t % 60) / 10), 4'(m_t % 10),
            m_tsup, (m_st == S_RUN), m_tick, m_err};
  endfunction

  wire [19:0] dut_out = {tens_min, unit_min, tens_sec, unit_sec, timesup, running, sec_tick, load_err};
  wire [15:0] digits  = {tens_min, unit_min, tens_sec, unit_sec};

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_out !== model_out()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got %h expected %h", $time, dut_out, model_out());
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input bit is_sec, input logic [3:0] t, input logic [3:0] u);
    set_sec = is_sec; set_min = !is_sec; tens_in = t; unit_in = u;
    cyc();
    set_sec = 0; set_min = 0;
  endtask

  task automatic go(input bit up);
    up_mode = up; start = 1;
    cyc();
    start = 0;
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    cyc();
    chk("reset_outputs", int'(dut_out), 0);
    reset = 0;
    cyc();

    // 00:03 countdown, step every T cycles, sticky DONE
    load(1, 4'd0, 4'd3);
    go(0);
    cyc(3); chk("pre_first_step", int'(digits), 'h0003);
    cyc();  chk("step1_digits", int'(digits), 'h0002); chk("step1_tick", int'(sec_tick), 1);
    cyc(4); chk("step2_digits", int'(digits), 'h0001);
    cyc(4); chk("final_digits", int'(digits), 'h0000);
    chk("final_timesup", int'(timesup), 1); chk("final_running", int'(running), 0);
    start = 1; cyc(5); start = 0;
    chk("done_sticky", int'(timesup), 1);
    load(1, 4'd0, 4'd7);
    chk("done_load_exit", int'(timesup), 0); chk("done_load_val", int'(digits), 'h0007);
    do_reset();

    // minute borrow and minute carry
    load(0, 4'd0, 4'd1);
    go(0); cyc(4); chk("borrow_0100", int'(digits), 'h0059);
    do_reset();
    load(0, 4'd0, 4'd9); load(1, 4'd5, 4'd9);
    go(1); cyc(4); chk("carry_0959", int'(digits), 'h1000);
    do_reset();

    // load validation and set_sec priority
    load(1, 4'd6, 4'd0);
    chk("bad_sec_err", int'(load_err), 1); chk("bad_sec_digits", int'(digits), 0);
    cyc(); chk("err_one_pulse", int'(load_err), 0);
    load(0, 4'd0, 4'hA); chk("bad_min_err", int'(load_err), 1);
    set_sec = 1; set_min = 1; tens_in = 4'd3; unit_in = 4'd4; cyc(); set_sec = 0; set_min = 0;
    chk("sec_wins", int'(digits), 'h0034);

    // pause after two prescaler counts, resume keeps phase
    go(0); cyc(2);
    pause = 1; cyc(); pause = 0;
    chk("paused", int'(running), 0);
    cyc(9);
    start = 1; cyc(); start = 0;
    chk("resumed", int'(running), 1);
    cyc(); chk("no_early_step", int'(sec_tick), 0);
    cyc(); chk("resume_step", int'(digits), 'h0033); chk("resume_tick", int'(sec_tick), 1);
    pause = 1; start = 1; cyc(); pause = 0; start = 0;
    chk("pause_wins", int'(running), 0);
    do_reset();

    // start at terminal values
    go(0);
    chk("zero_start_done", int'(timesup), 1); chk("zero_start_notick", int'(sec_tick), 0);
    ack = 1; cyc(); ack = 0;
    chk("ack_exit", int'(timesup), 0);
    load(0, 4'd9, 4'd9); load(1, 4'd5, 4'd9);
    go(1); chk("max_start_done", int'(timesup), 1);
    do_reset();

    // async reset in the middle of a run
    load(1, 4'd0, 4'd5);
    go(0); cyc(4);
    chk("pre_reset_tick", int'(sec_tick), 1);
    #2 reset = 1;
    #1 chk("async_reset", int'(dut_out), 0);
    cyc(); reset = 0;
    cyc(6);
    chk("post_reset_quiet", int'(dut_out), 0);

    // periodic countdown from 00:02
    load(1, 4'd0, 4'd2);
    go(0); cyc(4); chk("ar_step1", int'(digits), 'h0001);
    cyc(4);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    chk("ar_reload", int'(digits), 'h0002); chk("ar_pulse", int'(timesup), 1);
    chk("ar_running", int'(running), 1);
    cyc(); chk("ar_pulse_end", int'(timesup), 0);
    cyc(3); chk("ar_step3", int'(digits), 'h0001);
`else
    chk("nr_done", int'(digits), 'h0000); chk("nr_timesup", int'(timesup), 1);
    cyc(); chk("nr_hold", int'(timesup), 1);
`endif
    do_reset();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
